// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state, address and bit-index definitions for timer_cmp
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CMP    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_ENABLE       = 0;
    localparam int CTRL_PERIODIC     = 1;
    localparam int CTRL_MATCH_IRQ_EN = 2;
    localparam int CTRL_OVF_IRQ_EN   = 3;
    localparam int CTRL_W            = 4;

    localparam int STAT_MATCH = 0;
    localparam int STAT_OVF   = 1;

endpackage

// File: rtl/timer_cmp.sv
// rtl/timer_cmp.sv - compare/overflow timer controller driving an external up-counter
module timer_cmp
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] count_val,
    input  logic             overflow,
    output logic             cnt_en,
    output logic             cnt_clear,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] cfg_rdata,
    output logic             irq,
    input  logic             irq_ack
);

    state_t            state, state_n;
    logic [CTRL_W-1:0] ctrl;
    logic [WIDTH-1:0]  cmp;
    logic              match_pend, match_pend_n;
    logic              ovf_pend, ovf_pend_n;
    logic              match_q, ovf_q;
    logic              cnt_clear_n;

    logic ctrl_wr, cmp_wr, status_wr, wr_enable;
    logic match_lvl, match_evt, ovf_evt, periodic;

    assign ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
    assign cmp_wr    = cfg_we && (cfg_addr == ADDR_CMP);
    assign status_wr = cfg_we && (cfg_addr == ADDR_STATUS);
    assign wr_enable = cfg_wdata[CTRL_ENABLE];
    assign periodic  = ctrl[CTRL_PERIODIC];

    // count_val is stale while the clear is in flight, so no match is taken then
    assign match_lvl = (count_val >= cmp) && (cmp != '0);
    assign match_evt = match_lvl && !match_q && !cnt_clear;
    assign ovf_evt   = overflow && !ovf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            ctrl       <= '0;
            cmp        <= '0;
            match_pend <= 1'b0;
            ovf_pend   <= 1'b0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_clear  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_n;
            if (ctrl_wr) ctrl <= cfg_wdata[CTRL_W-1:0];
            if (cmp_wr)  cmp  <= cfg_wdata;
            match_pend <= match_pend_n;
            ovf_pend   <= ovf_pend_n;
            match_q    <= match_lvl;
            ovf_q      <= overflow;
            cnt_clear  <= cnt_clear_n;
            irq        <= (match_pend && ctrl[CTRL_MATCH_IRQ_EN]) ||
                          (ovf_pend && ctrl[CTRL_OVF_IRQ_EN]);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (ctrl_wr && wr_enable) state_n = ST_ARMED;
            ST_ARMED: begin
                if (ctrl_wr && !wr_enable)      state_n = ST_IDLE;
                else if (match_evt && !periodic) state_n = ST_FIRED;
            end
            ST_FIRED: if (irq_ack || (ctrl_wr && !wr_enable)) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // a one-shot match stops counting in the same cycle so the count holds at the match value
    always_comb begin
        cnt_en      = (state == ST_ARMED) && !(match_evt && !periodic);
        cnt_clear_n = ((state == ST_IDLE) && (state_n == ST_ARMED)) ||
                      ((state == ST_ARMED) && (state_n == ST_ARMED) && match_evt && periodic);
    end

    // clears are applied first so that a same-cycle event keeps its flag
    always_comb begin
        match_pend_n = match_pend;
        ovf_pend_n   = ovf_pend;
        if (irq_ack) begin
            match_pend_n = 1'b0;
            ovf_pend_n   = 1'b0;
        end
        if (status_wr && cfg_wdata[STAT_MATCH]) match_pend_n = 1'b0;
        if (status_wr && cfg_wdata[STAT_OVF])   ovf_pend_n   = 1'b0;
        if (match_evt && (state == ST_ARMED))   match_pend_n = 1'b1;
        if (ovf_evt)                            ovf_pend_n   = 1'b1;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_CTRL:   cfg_rdata[CTRL_W-1:0] = ctrl;
            ADDR_CMP:    cfg_rdata = cmp;
            ADDR_STATUS: cfg_rdata[3:0] = {state, ovf_pend, match_pend};
            default:     cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_cmp.sv
// tb/tb_timer_cmp.sv - directed, table-driven bench for timer_cmp with an up-counter model
module tb_timer_cmp;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] count_val;
    logic       overflow;
    logic       cnt_en, cnt_clear;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] cfg_rdata;
    logic       irq;
    logic       irq_ack = 1'b0;
    int         rate = 1;
    int         n_checks = 0;
    int         n_fail = 0;

    timer_cmp #(.WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .count_val(count_val), .overflow(overflow),
        .cnt_en(cnt_en), .cnt_clear(cnt_clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // upstream up-counter: overflow pulses on the increment that wraps
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_val <= 8'd0;
            overflow  <= 1'b0;
        end else if (cnt_clear) begin
            count_val <= 8'd0;
            overflow  <= 1'b0;
        end else if (cnt_en) begin
            {overflow, count_val} <= {1'b0, count_val} + 9'(rate);
        end else begin
            overflow <= 1'b0;
        end
    end

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [1:0] raddr;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_count(input string name, input logic [7:0] v, input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (count_val == v) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] d;
        int         last, pulses, maxc, k;
        logic [7:0] exp_seq[5];

        vecs[0] = '{1'b1, 2'd1, 8'h5A, 2'd1, 8'h5A};
        vecs[1] = '{1'b1, 2'd0, 8'hF2, 2'd0, 8'h02};
        vecs[2] = '{1'b1, 2'd3, 8'hFF, 2'd3, 8'h00};
        vecs[3] = '{1'b0, 2'd1, 8'h33, 2'd1, 8'h5A};
        vecs[4] = '{1'b1, 2'd2, 8'hFF, 2'd2, 8'h00};
        vecs[5] = '{1'b1, 2'd0, 8'h08, 2'd0, 8'h08};
        vecs[6] = '{1'b1, 2'd1, 8'h00, 2'd1, 8'h00};
        vecs[7] = '{1'b1, 2'd0, 8'h00, 2'd2, 8'h00};

        // reset state
        @(negedge clk);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_cnt_clear", 32'(cnt_clear), 32'd0);
        rd(2'd0, d); check("rst_ctrl", 32'(d), 32'd0);
        rd(2'd2, d); check("rst_status", 32'(d), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // register access table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
            @(negedge clk);
            cfg_we = 1'b0;
            rd(vecs[i].raddr, d);
            check($sformatf("reg_vec%0d", i), 32'(d), 32'(vecs[i].exp));
            check($sformatf("reg_vec%0d_cnt_en", i), 32'(cnt_en), 32'd0);
        end

        // one-shot, CMP=5
        @(negedge clk);
        wr(2'd1, 8'd5);
        wr(2'd0, 8'h05);
        check("os_clear_pulse", 32'(cnt_clear), 32'd1);
        check("os_cnt_en", 32'(cnt_en), 32'd1);
        @(negedge clk);
        check("os_clear_single", 32'(cnt_clear), 32'd0);
        check("os_count0", 32'(count_val), 32'd0);
        wait_count("os_reach5", 8'd5, 10);
        check("os_freeze_en", 32'(cnt_en), 32'd0);
        check("os_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        check("os_hold5", 32'(count_val), 32'd5);
        rd(2'd2, d); check("os_status_fired", 32'(d), 32'h9);
        check("os_irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        check("os_irq", 32'(irq), 32'd1);
        check("os_hold5b", 32'(count_val), 32'd5);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        rd(2'd2, d); check("os_ack_status", 32'(d), 32'h0);
        @(negedge clk);
        check("os_ack_irq", 32'(irq), 32'd0);

        // periodic, CMP=3
        wr(2'd1, 8'd3);
        wr(2'd0, 8'h07);
        last = -1; pulses = 0; maxc = 0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_clear) begin
                if (last >= 0) check("per_interval", 32'(i - last), 32'd5);
                last = i;
                pulses++;
            end
            if (i >= 1 && int'(count_val) > maxc) maxc = int'(count_val);
            @(negedge clk);
        end
        check("per_pulses", 32'(pulses), 32'd8);
        check("per_max", 32'(maxc), 32'd4);
        rd(2'd2, d); check("per_status", 32'(d), 32'h5);

        // ack alone clears, then ack colliding with a match event
        wait_count("per_wait1", 8'd1, 10);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        rd(2'd2, d); check("per_ack_clears", 32'(d[0]), 32'd0);
        wait_count("per_wait0", 8'd0, 10);
        wait_count("per_wait3", 8'd3, 10);
        check("col_irq_before", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        rd(2'd2, d); check("col_match_pend", 32'(d[0]), 32'd1);
        check("col_irq", 32'(irq), 32'd1);
        @(negedge clk);
        check("col_irq_next", 32'(irq), 32'd1);

        // disable from ARMED: no clear pulse
        wr(2'd0, 8'h00);
        check("dis_no_clear", 32'(cnt_clear), 32'd0);
        check("dis_cnt_en", 32'(cnt_en), 32'd0);
        rd(2'd2, d); check("dis_status", 32'(d), 32'h1);
        wr(2'd2, 8'h01);
        rd(2'd2, d); check("dis_status_w1c", 32'(d), 32'h0);

        // overflow with CMP=0
        @(negedge clk);
        wr(2'd1, 8'd0);
        wr(2'd0, 8'h09);
        k = 1;
        rd(2'd2, d);
        while (d[1] == 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
            rd(2'd2, d);
        end
        check("ovf_latency", 32'(k), 32'd259);
        check("ovf_status", 32'(d), 32'h6);
        @(negedge clk);
        check("ovf_irq", 32'(irq), 32'd1);
        wr(2'd2, 8'h02);
        rd(2'd2, d); check("ovf_w1c", 32'(d), 32'h4);
        wr(2'd0, 8'h00);

        // increment rate 3, CMP=7
        rate = 3;
        exp_seq[0] = 8'd0; exp_seq[1] = 8'd3; exp_seq[2] = 8'd6;
        exp_seq[3] = 8'd9; exp_seq[4] = 8'd9;
        wr(2'd1, 8'd7);
        wr(2'd0, 8'h05);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("r3_count%0d", j), 32'(count_val), 32'(exp_seq[j]));
        end
        @(negedge clk);
        check("r3_irq", 32'(irq), 32'd1);
        rd(2'd2, d); check("r3_status", 32'(d), 32'h9);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        rd(2'd2, d); check("r3_ack", 32'(d), 32'h0);

        // asynchronous reset while ARMED at count 4
        rate = 1;
        wr(2'd1, 8'd3);
        wr(2'd0, 8'h07);
        wait_count("rst_wait4a", 8'd4, 12);
        wait_count("rst_wait4b", 8'd4, 12);
        check("rst_pre_irq", 32'(irq), 32'd1);
        check("rst_pre_clear", 32'(cnt_clear), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_async_irq", 32'(irq), 32'd0);
        check("rst_async_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_async_clear", 32'(cnt_clear), 32'd0);
        rd(2'd0, d); check("rst_async_ctrl", 32'(d), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        rd(2'd2, d); check("rst_after_status", 32'(d), 32'd0);
        rd(2'd1, d); check("rst_after_cmp", 32'(d), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
